// File: rtl/tecla_scheduler.sv
// Frame-synchronous key-code sequencer for the piano renderer: arbitrates a 4-entry live-key FIFO
// against a demo source and holds each note for HOLD_FRAMES frames followed by one blank frame.
module tecla_scheduler #(
  parameter int unsigned HOLD_FRAMES = 6,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       key_valid,
  input  logic [5:0] key_code,
  output logic       key_ready,
  input  logic       demo_mode,
  input  logic       demo_valid,
  input  logic [5:0] demo_code,
  output logic       demo_ready,
  output logic [5:0] tecla,
  output logic       note_on,
  output logic       drop,
  output logic [2:0] fifo_count
);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  localparam logic [7:0] HoldInit = 8'(HOLD_FRAMES - 1);
  localparam logic [2:0] FifoFull = 3'(FIFO_DEPTH);
  localparam logic [5:0] MaxNote  = 6'd32;

  logic [5:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;

  state_e     r_state;
  logic [7:0] r_hold;
  logic [5:0] r_tecla;
  logic       r_note_on;
  logic       r_drop;

  logic w_key_ready;
  logic w_key_hs;
  logic w_key_ok;
  logic w_push;
  logic w_launch;
  logic w_pop;
  logic w_demo_hs;
  logic w_demo_bad;

  // A same-cycle pop is deliberately not credited: a full FIFO refuses the push.
  assign w_key_ready = !demo_mode && (r_count < FifoFull);
  assign w_key_hs    = key_valid && w_key_ready;
  assign w_key_ok    = (key_code != 6'd0) && (key_code <= MaxNote);
  assign w_push      = w_key_hs && w_key_ok;

  assign w_launch    = frame_start && (r_state != StShow);
  assign w_pop       = w_launch && !demo_mode && (r_count != 3'd0);
  assign w_demo_hs   = w_launch && demo_mode && demo_valid;
  assign w_demo_bad  = demo_code > MaxNote;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= (w_key_hs && !w_key_ok) || (w_demo_hs && w_demo_bad);
    end
  end

  // Everything visible to the renderer moves only on frame_start, so a key never tears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_hold    <= 8'd0;
      r_tecla   <= 6'd0;
      r_note_on <= 1'b0;
    end else if (frame_start) begin
      unique case (r_state)
        StIdle, StGap: begin
          if (demo_mode) begin
            if (demo_valid && !w_demo_bad) begin
              r_tecla   <= demo_code;
              r_note_on <= (demo_code != 6'd0);
              r_hold    <= HoldInit;
              r_state   <= StShow;
            end else begin
              r_tecla   <= 6'd0;
              r_note_on <= 1'b0;
              r_state   <= StIdle;
            end
          end else if (r_count != 3'd0) begin
            r_tecla   <= r_mem[r_rd_ptr];
            r_note_on <= 1'b1;
            r_hold    <= HoldInit;
            r_state   <= StShow;
          end else begin
            r_tecla   <= 6'd0;
            r_note_on <= 1'b0;
            r_state   <= StIdle;
          end
        end
        StShow: begin
          if (r_hold == 8'd0) begin
            r_tecla   <= 6'd0;
            r_note_on <= 1'b0;
            r_state   <= StGap;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end
        default: begin
          r_tecla   <= 6'd0;
          r_note_on <= 1'b0;
          r_state   <= StIdle;
        end
      endcase
    end
  end

  assign key_ready  = w_key_ready;
  assign demo_ready = w_launch && demo_mode;
  assign tecla      = r_tecla;
  assign note_on    = r_note_on;
  assign drop       = r_drop;
  assign fifo_count = r_count;

endmodule

// File: doc/tecla_scheduler.md
Name: tecla_scheduler

Overview:
- Sequences the 6-bit key code (tecla) that drives the piano VGA renderer and tone path.
- Arbitrates between two requesters: live keyboard events, buffered in a 4-entry FIFO, and a demo/playback source.
- Changes tecla only at frame boundaries, so a key never tears mid-frame.
- Shows each note for a fixed number of frames, then one blank frame, so repeated presses of the same key stay visible.

Parameters:
- HOLD_FRAMES, 6, number of frames a note stays on tecla; legal range 1..255 (8-bit counter).
- FIFO_DEPTH, 4, live-event FIFO entries; fixed at 4 (2-bit pointers, 3-bit count).

Ports:
- clock  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking (V_count==480, H_count==0) from VGA timing.
- key_valid  in  1  live key event request.
- key_code  in  6  live key code: 1..16 top row, 17..32 bottom row.
- key_ready  out  1  live event accepted when key_valid && key_ready.
- demo_mode  in  1  1 = demo source owns tecla; 0 = FIFO owns tecla.
- demo_valid  in  1  demo note available.
- demo_code  in  6  demo code: 0 = rest, 1..32 = note.
- demo_ready  out  1  demo note consumed when demo_valid && demo_ready.
- tecla  out  6  key code to renderer; 0 = no key.
- note_on  out  1  high while a non-rest note is displayed.
- drop  out  1  one-cycle pulse when an accepted code is discarded.
- fifo_count  out  3  live FIFO occupancy, 0..4.

Behaviour:
- Reset (async): tecla=0, note_on=0, drop=0, fifo_count=0, FIFO pointers cleared, hold counter=0, state=IDLE. Reset mid-note clears everything at once; no note resumes afterwards.
- key_ready = !demo_mode && fifo_count<4. This is combinational and does not credit a same-cycle pop; a full FIFO blocks a push even when it pops that cycle.
- Live push handshake:
  - key_code 1..32: written to the FIFO on the handshake cycle.
  - key_code 0 or 33..63: handshake completes, nothing is written, drop=1 for the next cycle.
- Simultaneous push and pop with a non-empty FIFO: count unchanged, data order preserved. FIFO pointers wrap modulo 4.
- FSM states: IDLE, SHOW, GAP. All state, tecla and counter changes occur only on cycles where frame_start=1. Outputs are registered, so tecla changes on the clock edge that samples frame_start.
- Launch rule, evaluated on frame_start in IDLE or GAP:
  - demo_mode=1: demo_ready=1 combinationally this cycle.
    - demo_valid with code 1..32: tecla<=code, note_on<=1, hold<=HOLD_FRAMES-1, go SHOW.
    - demo_valid with code 0 (rest): tecla<=0, note_on<=0, hold<=HOLD_FRAMES-1, go SHOW.
    - demo_valid with code >32: consumed, drop pulse, go IDLE.
    - demo_valid=0: go IDLE.
  - demo_mode=0 and FIFO non-empty: pop head, tecla<=head, note_on<=1, hold<=HOLD_FRAMES-1, go SHOW.
  - demo_mode=0 and FIFO empty: tecla<=0, go IDLE.
- demo_ready is 0 on every other cycle, and the FIFO never pops outside the launch rule.
- SHOW on frame_start:
  - hold==0: tecla<=0, note_on<=0, go GAP.
  - otherwise: hold<=hold-1.
- Resulting timing: a note is visible for exactly HOLD_FRAMES frames, followed by exactly one blank frame. The next launch is evaluated on the frame_start that ends GAP.
- Throughput: one note per HOLD_FRAMES+1 frames.
- demo_mode toggled mid-note: the current note completes normally. The new owner is sampled at the next launch. FIFO contents are retained while demo_mode=1.
- frame_start while in IDLE with nothing pending: stays IDLE, tecla remains 0.

Test Plan:
- Reset, then one live push of code 5 followed by frame_start pulses every 800x525 cycles → fifo_count 1→0 at the first frame_start; tecla=5 and note_on=1 for 6 frames; tecla=0 for 1 frame; then IDLE.
- Push codes 3,3,20,32 back-to-back, then push 7 while full → key_ready=0 for the 7. Display sequence is 3,(blank),3,(blank),20,(blank),32, each note 6 frames.
- Push codes 0 and 40 → both handshakes complete, drop pulses twice, fifo_count stays 0, tecla stays 0.
- demo_mode=1, demo stream 17,0,9 with demo_valid held → demo_ready pulses only on frame_start. Response: tecla=17 for 6 frames, blank, rest (tecla=0, note_on=0) for 6 frames, blank, then 9. key_ready=0 throughout.
- Live note 12 showing at hold=3 when demo_mode rises; FIFO holds 14 → 12 finishes its 6 frames and demo owns the next launch. After demo_mode falls, 14 is displayed.
- Assert reset asynchronously mid-SHOW with fifo_count=2 → tecla=0, note_on=0 and fifo_count=0 immediately, without waiting for a clock edge.
